// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SDRAM request port among N requesters.
// Grants one request at a time (round-robin by default) and keeps a tag FIFO
// of read owners so returning read words reach the requester that asked.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arbiter #(
  parameter int N     = 3,
  parameter int DEPTH = 8
) (
  input  logic              clkSYS,
  input  logic              n_reset,
  input  logic [24*N-1:0]   r_addr,
  input  logic [16*N-1:0]   r_data,
  input  logic [N-1:0]      r_req,
  input  logic [N-1:0]      r_wr,
  output logic [N-1:0]      r_ack,
  output logic [15:0]       r_mem,
  output logic [N-1:0]      r_valid,
  output logic [23:0]       addr,
  output logic [15:0]       data,
  output logic              req,
  output logic              wr,
  input  logic              ack,
  input  logic [15:0]       mem,
  input  logic              valid,
  output logic              err
);

  localparam int          PW   = (N > 1) ? $clog2(N) : 1;
  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW   = AW + 1;
  localparam int unsigned NU   = N;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   sel_q;
  logic [23:0]     addr_q;
  logic [15:0]     data_q;
  logic            wr_q;
  logic            req_q;
  logic            err_q;

  logic [PW-1:0]   tag_q [DEPTH];
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   rp_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic [N-1:0]    elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [23:0]     win_addr;
  logic [15:0]     win_data;
  logic            win_wr;
  logic            push;
  logic            pop;

  // Winner selection: scan indices >= ptr first, then wrap to the low indices.
  always_comb begin
    elig  = r_req & (r_wr | {N{count_q != FULL}});
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (!found && elig[i] && (PW'(i) >= ptr_q)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NU; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
  end

  // Mux the winning requester's address, data and direction.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    win_wr   = 1'b0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (PW'(i) == win) begin
        win_addr = r_addr[24*i +: 24];
        win_data = r_data[16*i +: 16];
        win_wr   = r_wr[i];
      end
    end
  end

  // Accept and read-return strobes, routed combinationally to their owners.
  always_comb begin
    push    = (state_q == GRANT) && ack && !wr_q;
    pop     = valid && (count_q != '0);
    count_d = count_q + CW'(push) - CW'(pop);
    r_ack   = '0;
    r_valid = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      r_ack[i]   = (state_q == GRANT) && ack && (sel_q == PW'(i));
      r_valid[i] = pop && (tag_q[rp_q] == PW'(i));
    end
  end

  // Arbitration FSM with registered controller-side outputs and sticky error.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (valid && (count_q == '0)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (found) begin
            sel_q   <= win;
            addr_q  <= win_addr;
            data_q  <= win_data;
            wr_q    <= win_wr;
            req_q   <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
`ifdef ARB_FIXED_PRIO_EN
            // ptr held at 0, so the selection scan reduces to lowest-index-first.
`else
            ptr_q   <= (sel_q == LAST) ? '0 : sel_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Tag storage; stale entries are unreachable after reset clears the pointers.
  always_ff @(posedge clkSYS) begin
    if (push) tag_q[wp_q] <= sel_q;
  end

  assign addr  = addr_q;
  assign data  = data_q;
  assign wr    = wr_q;
  assign req   = req_q;
  assign err   = err_q;
  assign r_mem = mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued when requests
// are driven and checked when the arbiter presents them; expected read owners
// are queued when a read is accepted and checked when valid returns.
module tb_mem_arbiter;
  localparam int N = 3;

  logic            clkSYS = 1'b0;
  logic            n_reset = 1'b0;
  logic [24*N-1:0] r_addr = '0;
  logic [16*N-1:0] r_data = '0;
  logic [N-1:0]    r_req = '0;
  logic [N-1:0]    r_wr = '0;
  logic [N-1:0]    r_ack;
  logic [15:0]     r_mem;
  logic [N-1:0]    r_valid;
  logic [23:0]     addr;
  logic [15:0]     data;
  logic            req;
  logic            wr;
  logic            ack = 1'b0;
  logic [15:0]     mem = '0;
  logic            valid = 1'b0;
  logic            err;

  typedef struct {
    int          owner;
    logic [23:0] a;
    logic [15:0] d;
    logic        w;
  } grant_t;

  grant_t gq[$];
  int     rq[$];
  int     total = 0;
  int     bad = 0;

  logic [23:0] A [N] = '{24'h000100, 24'h080010, 24'h100200};
  logic [15:0] D [N] = '{16'h1a2b, 16'h667f, 16'h3c4d};

  mem_arbiter #(.N(3), .DEPTH(8)) dut (
    .clkSYS(clkSYS), .n_reset(n_reset), .r_addr(r_addr), .r_data(r_data),
    .r_req(r_req), .r_wr(r_wr), .r_ack(r_ack), .r_mem(r_mem), .r_valid(r_valid),
    .addr(addr), .data(data), .req(req), .wr(wr), .ack(ack), .mem(mem),
    .valid(valid), .err(err)
  );

  always #5 clkSYS = ~clkSYS;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clkSYS);
    #1;
  endtask

  task automatic do_reset();
    r_req = '0; ack = 1'b0; valid = 1'b0;
    n_reset = 1'b0;
    gq.delete(); rq.delete();
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic request(input int i, input logic w);
    r_req[i] = 1'b1;
    r_wr[i]  = w;
    gq.push_back('{i, A[i], D[i], w});
  endtask

  // Emulates the SDRAM controller for one transaction.
  task automatic serve(input int lat, input bit hold, input bit vp,
                       input logic [15:0] vm, output int waited);
    grant_t e;
    int eo;
    logic [N-1:0] ev;
    waited = 0;
    while (req !== 1'b1 && waited < 40) begin tick(); waited++; end
    total++;
    if (req !== 1'b1 || gq.size() == 0) begin
      bad++;
      $display("FAIL grant_timeout req=%b want=1 pending=%0d", req, gq.size());
      return;
    end
    e = gq.pop_front();
    total++;
    if (addr !== e.a || data !== e.d || wr !== e.w) begin
      bad++;
      $display("FAIL grant_fields owner=%0d addr=%h want=%h data=%h want=%h wr=%b want=%b",
               e.owner, addr, e.a, data, e.d, wr, e.w);
    end
    repeat (lat) tick();
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL req_hold req=%b want=1", req); end
    ack = 1'b1;
    if (vp) begin valid = 1'b1; mem = vm; end
    #1;
    total++;
    if (r_ack !== N'(1 << e.owner)) begin
      bad++; $display("FAIL r_ack got=%b want=%b", r_ack, N'(1 << e.owner));
    end
    if (vp) begin
      eo = (rq.size() > 0) ? rq.pop_front() : -1;
      ev = (eo < 0) ? '0 : N'(1 << eo);
      total++;
      if (r_valid !== ev || r_mem !== vm) begin
        bad++;
        $display("FAIL pushpop_valid r_valid=%b want=%b r_mem=%h want=%h", r_valid, ev, r_mem, vm);
      end
    end
    if (!e.w) rq.push_back(e.owner);
    tick();
    ack = 1'b0; valid = 1'b0;
    if (!hold) r_req[e.owner] = 1'b0;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL req_drop req=%b want=0", req); end
  endtask

  // One valid pulse from the controller; owner comes from the scoreboard.
  task automatic do_valid(input logic [15:0] m);
    int eo;
    logic [N-1:0] ev;
    valid = 1'b1; mem = m;
    #1;
    eo = (rq.size() > 0) ? rq.pop_front() : -1;
    ev = (eo < 0) ? '0 : N'(1 << eo);
    total++;
    if (r_valid !== ev || r_mem !== m) begin
      bad++;
      $display("FAIL read_route r_valid=%b want=%b r_mem=%h want=%h", r_valid, ev, r_mem, m);
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    total++;
    if (req !== 1'b0 || wr !== 1'b0 || addr !== '0 || data !== '0) begin
      bad++; $display("FAIL reset_ctrl req=%b wr=%b addr=%h data=%h want all 0", req, wr, addr, data);
    end
    total++;
    if (r_ack !== '0 || r_valid !== '0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_strobes r_ack=%b r_valid=%b err=%b want all 0", r_ack, r_valid, err);
    end
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int w;
    do_reset();
    request(1, 1'b1);
    serve(2, 1'b0, 1'b0, 16'h0, w);
    total++;
    if (w !== 1) begin bad++; $display("FAIL grant_latency got=%0d want=1", w); end
  endtask

  task automatic test_round_robin();
    int w;
    int exp_o;
    do_reset();
    r_wr = '1;
    r_req = '1;
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) begin
`ifdef ARB_FIXED_PRIO_EN
        exp_o = 0;
`else
        exp_o = i;
`endif
        gq.push_back('{exp_o, A[exp_o], D[exp_o], 1'b1});
      end
    for (int k = 0; k < 2 * N; k++) serve(0, 1'b1, 1'b0, 16'h0, w);
    r_req = '0;
    tick(); tick();
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL rr_quiet req=%b want=0", req); end
  endtask

  task automatic test_read_routing();
    int w;
    do_reset();
    request(2, 1'b0);
    serve(1, 1'b0, 1'b0, 16'h0, w);
    request(0, 1'b0);
    serve(1, 1'b0, 1'b0, 16'h0, w);
    tick(); tick();
    do_valid(16'h1234);
    tick();
    do_valid(16'h5678);
  endtask

  task automatic test_fifo_full();
    int w;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      request(i % N, 1'b0);
      serve(1, 1'b0, 1'b0, 16'h0, w);
    end
    r_req[0] = 1'b1; r_wr[0] = 1'b0;
    request(1, 1'b1);
    serve(1, 1'b0, 1'b0, 16'h0, w);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (req !== 1'b0) begin bad++; $display("FAIL full_mask req=%b want=0 cycle=%0d", req, k); end
    end
    gq.push_back('{0, A[0], D[0], 1'b0});
    do_valid(16'ha000);
    serve(1, 1'b0, 1'b0, 16'h0, w);
    for (int k = 0; k < 8; k++) do_valid(16'hb000 + 16'(k));
  endtask

  task automatic test_push_pop();
    int w;
    do_reset();
    request(2, 1'b0);
    serve(1, 1'b0, 1'b0, 16'h0, w);
    request(0, 1'b0);
    serve(1, 1'b0, 1'b1, 16'h1111, w);
    do_valid(16'h2222);
    do_valid(16'h3333);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL pushpop_err err=%b want=1", err); end
  endtask

  task automatic test_error_reset();
    int w;
    do_reset();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_cleared err=%b want=0", err); end
    do_valid(16'h4444);
    tick();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky err=%b want=1", err); end
    request(1, 1'b0);
    serve(1, 1'b0, 1'b0, 16'h0, w);
    request(2, 1'b1);
    w = 0;
    while (req !== 1'b1 && w < 40) begin tick(); w++; end
    ack = 1'b1;
    n_reset = 1'b0;
    #1;
    total++;
    if (req !== 1'b0 || err !== 1'b0 || r_ack !== '0) begin
      bad++; $display("FAIL reset_in_grant req=%b err=%b r_ack=%b want all 0", req, err, r_ack);
    end
    ack = 1'b0; r_req = '0;
    gq.delete(); rq.delete();
    tick();
    n_reset = 1'b1;
    tick();
    do_valid(16'h5555);
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL reset_idle req=%b want=0", req); end
  endtask

  initial begin
    r_addr = '0;
    r_data = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[24*i +: 24] = A[i];
      r_data[16*i +: 16] = D[i];
    end
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_fifo_full();
    test_push_pop();
    test_error_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
